collect_controller: RTL
=======================

Name: collect_controller

Overview:
- Sequencing FSM for the sum/collected accumulator datapath.
- Accepts 4-bit items over a valid/ready handshake and drives add_sum, rs_sum and rs_col so that each accepted item is added exactly once.
- Watches the datapath's sum and reports success when it reaches TARGET.
- Reports failure on item-count exhaustion or input inactivity timeout.
- Sits between the item source, which drives data directly into the datapath, and the datapath itself.

Parameters:
- TARGET, 8'd50: success threshold on sum. Legal range is 1..240, which guarantees sum never wraps.
- MAX_ITEMS, 16: maximum accepted items per session. Legal range is 1..31.
- TIMEOUT, 255: idle cycles allowed in COLLECT with no accepted item before failing. Legal range is 1..255.

Ports:
- clock, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a session. Sampled only in IDLE.
- abort, input, 1: return to IDLE from any state.
- ack, input, 1: acknowledge DONE or FAIL.
- in_valid, input, 1: source presents an item on the datapath data bus.
- in_ready, output, 1: controller can accept an item this cycle.
- sum, input, 8: datapath sum feedback.
- collected, input, 1: datapath collected feedback.
- add_sum, output, 1: datapath control.
- rs_sum, output, 1: datapath control.
- rs_col, output, 1: datapath control.
- busy, output, 1: session in progress (CLEAR, COLLECT or CHECK).
- done, output, 1: TARGET reached.
- fail, output, 1: session failed.
- fail_code, output, 2: 00 none, 01 item limit, 10 timeout, 11 reserved.
- item_count, output, 5: items accepted in the current session.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state goes to IDLE.
  - item_count=0, idle timer=0, fail_code=00.
  - done=0, fail=0, busy=0, in_ready=0.
- Control outputs are decoded from state; add_sum and in_ready are Mealy.
- IDLE:
  - rs_sum=1, rs_col=1, add_sum=0. This holds the datapath at sum=0, collected=0.
  - start=1 moves to CLEAR.
- CLEAR (1 cycle):
  - rs_sum=1, rs_col=1.
  - item_count and timer are cleared.
  - Moves to COLLECT.
- COLLECT:
  - in_ready=1, rs_sum=0.
  - Handshake: in_valid=1 gives add_sum=1 in the same cycle, and rs_col=0 in the same cycle, so collected=1 from the next edge.
  - On handshake: item_count+1, timer cleared, move to CHECK.
  - Without handshake: add_sum=0, timer+1. When the timer reaches TIMEOUT-1 with no handshake, move to FAIL with fail_code=10.
- CHECK (1 cycle; the sum seen here already includes the item):
  - in_ready=0, add_sum=0, rs_sum=0, rs_col=0.
  - Priority order:
    1. sum>=TARGET moves to DONE.
    2. Otherwise item_count==MAX_ITEMS moves to FAIL, fail_code=01.
    3. Otherwise return to COLLECT.
- DONE:
  - done=1. add_sum=0, rs_sum=0, rs_col=0, so the final sum and collected=1 are held.
  - ack=1 moves to IDLE; done drops on the same edge.
- FAIL:
  - fail=1. Sum is held as in DONE.
  - ack moves to IDLE.
  - fail_code holds until the next CLEAR.
- Per-item rule: throughput is at most 1 item per 2 cycles, because CHECK is a bubble. A source holding in_valid during CHECK is not accepted until COLLECT.
- abort:
  - Highest priority in every state. The next state is IDLE.
  - In the abort cycle add_sum is forced to 0 and in_ready to 0, so an item offered that cycle is not accepted.
  - done and fail read 0 in IDLE.
- Ignored inputs:
  - start outside IDLE is ignored.
  - ack outside DONE and FAIL is ignored.
  - start and ack together in IDLE: start wins.
- Reset mid-session: the asynchronous reset returns the controller to IDLE immediately. The datapath clears on the following clock edges because IDLE drives rs_sum=1 and rs_col=1.
- Arithmetic:
  - Sum comparison is unsigned 8-bit.
  - TARGET<=240 with a 4-bit item means the sum before an add is at most 239, so after the add it is at most 254 and never wraps.
  - item_count never exceeds MAX_ITEMS.

Decomposition:
- Package collect_pkg:
  - State enum: IDLE, CLEAR, COLLECT, CHECK, DONE, FAIL.
  - fail_code constants: FC_NONE, FC_LIMIT, FC_TIMEOUT.
  - Timer width constant.
- One sub-module, collect_idle_timer:
  - Ports: clear, enable, expired.
  - 8-bit counter with asynchronous active-low reset.
  - expired is asserted when count==TIMEOUT-1 and enable=1.

Test Plan:
- Reset then start, then items 15,15,15,5, each with in_valid held 1 cycle in COLLECT:
  - in_ready pulses every 2 cycles.
  - sum reaches 50 after the 4th item.
  - done=1 in the cycle after CHECK, item_count=4, collected=1.
  - ack returns to IDLE and sum reads 0 two edges later.
- MAX_ITEMS=3, TARGET=50, items 1,2,3:
  - FAIL with fail_code=01, item_count=3, sum held at 6.
- Start, then no in_valid:
  - FAIL with fail_code=10 exactly TIMEOUT cycles after entering COLLECT.
  - Repeat with an item at cycle TIMEOUT-2: the timer restarts and no fail occurs.
- Abort asserted in the same cycle as in_valid in COLLECT:
  - No add (sum unchanged), state goes to IDLE, done=0, fail=0.
- reset_n pulsed low asynchronously between clock edges in CHECK:
  - Outputs go to reset values immediately.
  - The following start begins with item_count=0 and sum=0 after CLEAR.
- in_valid held continuously with data=4, TARGET=12:
  - Exactly 3 accepts in 6 cycles.
  - add_sum is never high in CHECK.
  - done with sum=12.

Source files
------------

// File: rtl/collect_pkg.sv
// Shared types and constants for the collect controller and its idle timer.
package collect_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StCollect,
        StCheck,
        StDone,
        StFail
    } state_e;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_LIMIT   = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    localparam int unsigned TIMER_W = 8;
    localparam int unsigned COUNT_W = 5;
    localparam int unsigned SUM_W   = 8;

endpackage

// File: rtl/collect_controller_if.sv
// Handshake, datapath control and status bundle between the controller and its environment.
interface collect_controller_if;
    import collect_pkg::*;

    logic               start;
    logic               abort;
    logic               ack;
    logic               in_valid;
    logic               in_ready;
    logic [SUM_W-1:0]   sum;
    logic               collected;
    logic               add_sum;
    logic               rs_sum;
    logic               rs_col;
    logic               busy;
    logic               done;
    logic               fail;
    logic [1:0]         fail_code;
    logic [COUNT_W-1:0] item_count;

    modport slave (
        input  start, abort, ack, in_valid, sum, collected,
        output in_ready, add_sum, rs_sum, rs_col, busy, done, fail, fail_code, item_count
    );

    modport master (
        output start, abort, ack, in_valid, sum, collected,
        input  in_ready, add_sum, rs_sum, rs_col, busy, done, fail, fail_code, item_count
    );

endinterface

// File: rtl/collect_idle_timer.sv
// Counts COLLECT cycles without an accepted item; flags the last allowed idle cycle.
module collect_idle_timer
    import collect_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TIMER_W'(1);
        end
    end

    assign o_expired = i_enable && (r_count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/collect_controller.sv
// Sequencing FSM for the sum/collected accumulator: one add per accepted item, then a
// CHECK bubble that judges the updated sum against TARGET and the item limit.
module collect_controller
    import collect_pkg::*;
#(
    parameter logic [SUM_W-1:0] TARGET    = 8'd50,
    parameter int unsigned      MAX_ITEMS = 16,
    parameter int unsigned      TIMEOUT   = 255
) (
    input  logic                 clock,
    input  logic                 reset_n,
    collect_controller_if.slave  bus
);

    state_e             r_state;
    state_e             w_state_next;
    logic [COUNT_W-1:0] r_item_count;
    logic [COUNT_W-1:0] w_item_count_next;
    logic [1:0]         r_fail_code;
    logic [1:0]         w_fail_code_next;
    logic               w_handshake;
    logic               w_timer_clear;
    logic               w_timer_enable;
    logic               w_timer_expired;

    // abort masks the handshake so an item offered in the abort cycle is never added
    assign w_handshake    = (r_state == StCollect) && bus.in_valid && !bus.abort;
    assign w_timer_clear  = (r_state == StClear) || w_handshake;
    assign w_timer_enable = (r_state == StCollect) && !w_handshake;

    collect_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_enable),
        .o_expired (w_timer_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_item_count <= '0;
            r_fail_code  <= FC_NONE;
        end else begin
            r_state      <= w_state_next;
            r_item_count <= w_item_count_next;
            r_fail_code  <= w_fail_code_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_item_count_next = r_item_count;
        w_fail_code_next  = r_fail_code;
        bus.in_ready      = 1'b0;
        bus.add_sum       = 1'b0;
        bus.rs_sum        = 1'b0;
        bus.rs_col        = 1'b0;
        bus.busy          = 1'b0;
        bus.done          = 1'b0;
        bus.fail          = 1'b0;

        unique case (r_state)
            StIdle: begin
                bus.rs_sum = 1'b1;
                bus.rs_col = 1'b1;
                if (bus.start) w_state_next = StClear;
            end
            StClear: begin
                bus.rs_sum        = 1'b1;
                bus.rs_col        = 1'b1;
                bus.busy          = 1'b1;
                w_item_count_next = '0;
                w_fail_code_next  = FC_NONE;
                w_state_next      = StCollect;
            end
            StCollect: begin
                bus.busy     = 1'b1;
                bus.in_ready = !bus.abort;
                bus.add_sum  = w_handshake;
                bus.rs_col   = !w_handshake;
                if (w_handshake) begin
                    w_item_count_next = r_item_count + COUNT_W'(1);
                    w_state_next      = StCheck;
                end else if (w_timer_expired) begin
                    w_fail_code_next = FC_TIMEOUT;
                    w_state_next     = StFail;
                end
            end
            StCheck: begin
                bus.busy = 1'b1;
                if (bus.sum >= TARGET) begin
                    w_state_next = StDone;
                end else if (r_item_count == COUNT_W'(MAX_ITEMS)) begin
                    w_fail_code_next = FC_LIMIT;
                    w_state_next     = StFail;
                end else begin
                    w_state_next = StCollect;
                end
            end
            StDone: begin
                bus.done = 1'b1;
                if (bus.ack) w_state_next = StIdle;
            end
            StFail: begin
                bus.fail = 1'b1;
                if (bus.ack) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase

        // abort overrides every transition and leaves the counters untouched
        if (bus.abort) begin
            w_state_next      = StIdle;
            w_item_count_next = r_item_count;
            w_fail_code_next  = r_fail_code;
        end
    end

    assign bus.fail_code  = r_fail_code;
    assign bus.item_count = r_item_count;

endmodule
